// File: rtl/jk_register_bank.sv
// Bank of JK flip-flops with per-bit J/K, clock enable, up/down counting and
// parallel load; every mode is expressed as J/K drive into the same JK update.
module jk_register_bank #(
    parameter int                 WIDTH     = 4,
    parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             tc,
    output logic             changed
);

    localparam logic [1:0] MODE_JK   = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             changed_q;
    logic             changed_d;
    logic [WIDTH-1:0] t_up_s;
    logic [WIDTH-1:0] t_dn_s;
    logic [WIDTH-1:0] j_s;
    logic [WIDTH-1:0] k_s;
    logic [WIDTH-1:0] q_jk_s;

    // Toggle chains: a bit toggles when every lower bit is 1 (up) or 0 (down)
    assign t_up_s[0] = 1'b1;
    assign t_dn_s[0] = 1'b1;
    for (genvar gi = 1; gi < WIDTH; gi++) begin : g_chain
        assign t_up_s[gi] = &q_q[gi-1:0];
        assign t_dn_s[gi] = ~|q_q[gi-1:0];
    end

    // Map the selected mode onto per-bit J/K drive
    always_comb begin
        j_s = {WIDTH{1'b0}};
        k_s = {WIDTH{1'b0}};
        case (mode)
            MODE_JK: begin
                j_s = j;
                k_s = k;
            end
            MODE_UP: begin
                j_s = t_up_s;
                k_s = t_up_s;
            end
            MODE_DOWN: begin
                j_s = t_dn_s;
                k_s = t_dn_s;
            end
            MODE_LOAD: begin
                j_s = d;
                k_s = ~d;
            end
            default: begin
                j_s = {WIDTH{1'b0}};
                k_s = {WIDTH{1'b0}};
            end
        endcase
    end

    assign q_jk_s = (j_s & ~q_q) | (~k_s & q_q);

    // Next-state selection: reset beats enable, disabled edges hold
    always_comb begin
        q_d       = q_q;
        changed_d = 1'b0;
        if (reset) begin
            q_d       = RESET_VAL;
            changed_d = 1'b0;
        end else if (en) begin
            q_d       = q_jk_s;
            changed_d = (q_jk_s != q_q);
        end else begin
            q_d       = q_q;
            changed_d = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        q_q       <= q_d;
        changed_q <= changed_d;
    end

    assign q       = q_q;
    assign qn      = ~q_q;
    assign changed = changed_q;
    assign tc      = ((mode == MODE_UP) && (&q_q)) || ((mode == MODE_DOWN) && (~|q_q));

endmodule

// File: tb/tb_jk_register_bank.sv
// Directed checks on a 4-bit bank plus a randomised run of an 8-bit bank
// (RESET_VAL=0A) against a behavioural model.
module tb_jk_register_bank;

    logic       clk = 1'b0;
    logic       reset, en;
    logic [1:0] mode;
    logic [3:0] j, k, d;
    logic [3:0] q, qn;
    logic       tc, changed;

    logic       r8, en8;
    logic [1:0] mode8;
    logic [7:0] j8, k8, d8;
    logic [7:0] q8, qn8;
    logic       tc8, changed8;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_q, m_n;
    logic       m_ch;

    always #5 clk = ~clk;

    jk_register_bank #(.WIDTH(4), .RESET_VAL(4'h0)) dut4 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .j(j), .k(k), .d(d),
        .q(q), .qn(qn), .tc(tc), .changed(changed)
    );

    jk_register_bank #(.WIDTH(8), .RESET_VAL(8'h0A)) dut8 (
        .clk(clk), .reset(r8), .en(en8), .mode(mode8), .j(j8), .k(k8), .d(d8),
        .q(q8), .qn(qn8), .tc(tc8), .changed(changed8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; en = 1'b1; mode = 2'b11; j = 4'h0; k = 4'h0; d = 4'hF;
        r8 = 1'b1; en8 = 1'b1; mode8 = 2'b11; j8 = 8'h00; k8 = 8'h00; d8 = 8'hFF;
        tick();
        chk("rst_q", {4'h0, q}, 8'h00);
        chk("rst_qn", {4'h0, qn}, 8'h0F);
        chk("rst_changed", {7'h0, changed}, 8'h00);
        chk("rst_tc", {7'h0, tc}, 8'h00);
        chk("rst8_q", q8, 8'h0A);
        chk("rst8_qn", qn8, 8'hF5);

        // JK mode: set, toggle, clear, hold
        reset = 1'b0; mode = 2'b00; j = 4'h5; k = 4'h0;
        tick();
        chk("jk_set_q", {4'h0, q}, 8'h05);
        chk("jk_set_ch", {7'h0, changed}, 8'h01);
        j = 4'hF; k = 4'hF;
        tick();
        chk("jk_tog_q", {4'h0, q}, 8'h0A);
        chk("jk_tog_ch", {7'h0, changed}, 8'h01);
        j = 4'h0; k = 4'hF;
        tick();
        chk("jk_clr_q", {4'h0, q}, 8'h00);
        chk("jk_clr_ch", {7'h0, changed}, 8'h01);
        k = 4'h0;
        tick();
        chk("jk_hold_q", {4'h0, q}, 8'h00);
        chk("jk_hold_ch", {7'h0, changed}, 8'h00);
        chk("jk_tc", {7'h0, tc}, 8'h00);

        // Up count through the wrap
        mode = 2'b01;
        for (int i = 1; i <= 17; i++) begin
            tick();
            chk("up_q", {4'h0, q}, 8'(i % 16));
            chk("up_tc", {7'h0, tc}, ((i % 16) == 15) ? 8'h01 : 8'h00);
            chk("up_ch", {7'h0, changed}, 8'h01);
        end
        chk("up_qn", {4'h0, qn}, 8'h0E);

        // Enable low mid-count
        tick();
        chk("up2_q", {4'h0, q}, 8'h02);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("en_hold_q", {4'h0, q}, 8'h02);
            chk("en_hold_ch", {7'h0, changed}, 8'h00);
        end
        en = 1'b1;

        // Down count from 2 through zero; tc follows mode immediately
        mode = 2'b10;
        tick();
        chk("dn_q1", {4'h0, q}, 8'h01);
        chk("dn_tc1", {7'h0, tc}, 8'h00);
        tick();
        chk("dn_q0", {4'h0, q}, 8'h00);
        chk("dn_tc0", {7'h0, tc}, 8'h01);
        tick();
        chk("dn_qF", {4'h0, q}, 8'h0F);
        chk("dn_tcF", {7'h0, tc}, 8'h00);
        mode = 2'b01;
        #1;
        chk("sw_tc", {7'h0, tc}, 8'h01);
        tick();
        chk("sw_q", {4'h0, q}, 8'h00);
        chk("sw_tc0", {7'h0, tc}, 8'h00);

        // Load, equal reload, reset mid-count
        mode = 2'b11; d = 4'h9;
        tick();
        chk("ld_q", {4'h0, q}, 8'h09);
        chk("ld_ch", {7'h0, changed}, 8'h01);
        tick();
        chk("ld_eq_q", {4'h0, q}, 8'h09);
        chk("ld_eq_ch", {7'h0, changed}, 8'h00);
        d = 4'h6;
        tick();
        mode = 2'b01;
        tick();
        chk("pre_rst_q", {4'h0, q}, 8'h07);
        reset = 1'b1;
        tick();
        chk("mid_rst_q", {4'h0, q}, 8'h00);
        chk("mid_rst_ch", {7'h0, changed}, 8'h00);
        reset = 1'b0;
        tick();
        chk("post_rst_q", {4'h0, q}, 8'h01);
        en = 1'b0;

        // Randomised 8-bit run against a behavioural model
        m_q = 8'h0A;
        for (int c = 0; c < 1000; c++) begin
            r8    = ($urandom_range(0, 31) == 0);
            en8   = ($urandom_range(0, 7) != 0);
            mode8 = 2'($urandom_range(0, 3));
            j8    = 8'($urandom);
            k8    = 8'($urandom);
            d8    = (($urandom_range(0, 3) == 0) ? m_q : 8'($urandom));
            if ($urandom_range(0, 15) == 0) begin
                d8 = 8'hFF;
            end
            #1;
            chk("rnd_tc", {7'h0, tc8},
                (((mode8 == 2'b01) && (m_q == 8'hFF)) || ((mode8 == 2'b10) && (m_q == 8'h00))) ? 8'h01 : 8'h00);
            m_n = m_q;
            if (r8) begin
                m_n = 8'h0A;
            end else if (en8) begin
                case (mode8)
                    2'b00: begin
                        for (int b = 0; b < 8; b++) begin
                            case ({j8[b], k8[b]})
                                2'b01: m_n[b] = 1'b0;
                                2'b10: m_n[b] = 1'b1;
                                2'b11: m_n[b] = ~m_q[b];
                                default: m_n[b] = m_q[b];
                            endcase
                        end
                    end
                    2'b01: m_n = m_q + 8'd1;
                    2'b10: m_n = m_q - 8'd1;
                    default: m_n = d8;
                endcase
            end
            m_ch = (!r8 && en8 && (m_n != m_q));
            tick();
            m_q = m_n;
            chk("rnd_q", q8, m_q);
            chk("rnd_qn", qn8, ~m_q);
            chk("rnd_ch", {7'h0, changed8}, {7'h0, m_ch});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
